// File: rtl/apb_initiator_pkg.sv
// Shared APB definitions: FSM encodings, direction constant and the
// wait-counter sizing rule used by the initiator and the completer BIU.
package apb_initiator_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   localparam logic PWRITE_WRITE = 1'b1;

   // Width that can hold TIMEOUT_CYCLES; never narrower than one bit.
   function automatic int wait_cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_initiator_if.sv
// Request, response and APB signals of the initiator in one bundle.
// master = initiator view, slave = requester/completer environment view.
interface apb_initiator_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_rnw;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic [ADDR_WIDTH-1:0] apb_paddr;
   logic                  apb_psel;
   logic                  apb_penable;
   logic                  apb_pwrite;
   logic [DATA_WIDTH-1:0] apb_pwdata;
   logic [DATA_WIDTH-1:0] apb_prdata;
   logic                  apb_pready;

   modport master (
      input  req_valid, req_addr, req_rnw, req_wdata, rsp_ready,
             apb_prdata, apb_pready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata
   );

   modport slave (
      output req_valid, req_addr, req_rnw, req_wdata, rsp_ready,
             apb_prdata, apb_pready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata
   );
endinterface

// File: rtl/apb_initiator_wait_timer.sv
// Saturating ACCESS wait counter; expired marks the last permitted
// wait cycle. TIMEOUT_CYCLES=0 never expires.
module apb_wait_timer
   import apb_initiator_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);
   localparam int               CNT_W    = wait_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_initiator.sv
// APB requester BIU: one request at a time through SETUP/ACCESS, result
// held on the response channel until taken. All outputs are registered.
module apb_initiator
   import apb_initiator_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst,
   apb_initiator_if.master   bus
);
   apb_state_e            state_q, state_d;
   logic                  req_ready_q, req_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  tmr_clr, tmr_inc, tmr_expired;

   apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .inc     (tmr_inc),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      paddr_d     = paddr_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      tmr_clr     = 1'b0;
      tmr_inc     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               paddr_d     = bus.req_addr;
               pwrite_d    = bus.req_rnw ? ~PWRITE_WRITE : PWRITE_WRITE;
               pwdata_d    = bus.req_wdata;
               psel_d      = 1'b1;
               req_ready_d = 1'b0;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            tmr_clr   = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (bus.apb_pready) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = (pwrite_q == PWRITE_WRITE) ? '0 : bus.apb_prdata;
               state_d     = RESP;
            end else if (tmr_expired) begin
               // Completer never answered: abandon the transfer, report error.
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = RESP;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         paddr_q     <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         paddr_q     <= paddr_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.apb_paddr   = paddr_q;
   assign bus.apb_psel    = psel_q;
   assign bus.apb_penable = penable_q;
   assign bus.apb_pwrite  = pwrite_q;
   assign bus.apb_pwdata  = pwdata_q;

endmodule
